// File: rtl/png_feed_ctrl.sv
// png_feed_ctrl: streams captured packets byte-wise, MSB-first, into the PNG decoder byte handshake.
// Optional destination-port filter is compiled in when PORT_FILTER_EN is defined.
module png_feed_ctrl #(
    parameter int unsigned NBYTES   = 69,
    parameter logic [15:0] PNG_PORT = 16'd8080
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [8*NBYTES-1:0]   pkt_data,
    input  logic [31:0]           pkt_ip,
    input  logic [15:0]           pkt_port,
    input  logic                  pkt_first,
    input  logic [6:0]            pkt_nbytes,
    output logic                  ostart,
    output logic                  ovalid,
    output logic [7:0]            obyte,
    input  logic                  iready,
    output logic                  busy,
    output logic [31:0]           last_ip,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           drop_cnt
);

    localparam int unsigned DW = 8 * NBYTES;
    localparam int unsigned CW = 7;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic            spend_q, spend_d;
    logic [31:0]     last_ip_q, last_ip_d;
    logic [15:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CW-1:0]   nbytes_c;
    logic            port_ok_c;
    logic            drop_inc_c;

    // Zero or oversize byte counts mean a full packet.
    assign nbytes_c = (pkt_nbytes == 7'd0 || pkt_nbytes > CW'(NBYTES)) ? CW'(NBYTES) : pkt_nbytes;

`ifdef PORT_FILTER_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign port_ok_c  = (pkt_port == PNG_PORT);
    assign drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q :
                        (drop_inc_c ? drop_cnt_q + 16'd1 : drop_cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_filter;

    assign port_ok_c     = 1'b1;
    assign drop_cnt      = 16'd0;
    assign unused_filter = ^{pkt_port, PNG_PORT, drop_inc_c};
`endif

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        rem_d      = rem_q;
        spend_d    = spend_q;
        last_ip_d  = last_ip_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_inc_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    if (port_ok_c) begin
                        sreg_d    = pkt_data;
                        rem_d     = nbytes_c;
                        spend_d   = pkt_first;
                        last_ip_d = pkt_ip;
                        pkt_cnt_d = (pkt_cnt_q == 16'hFFFF) ? pkt_cnt_q : pkt_cnt_q + 16'd1;
                        state_d   = S_STREAM;
                    end else begin
                        drop_inc_c = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (iready) begin
                    sreg_d  = {sreg_q[DW-9:0], 8'h00};
                    rem_d   = rem_q - 7'd1;
                    spend_d = 1'b0;
                    if (rem_q == 7'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            rem_q     <= '0;
            spend_q   <= 1'b0;
            last_ip_q <= 32'd0;
            pkt_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            rem_q     <= rem_d;
            spend_q   <= spend_d;
            last_ip_q <= last_ip_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Handshake flags decode the state register directly.
    assign pkt_ready = (state_q == S_IDLE);
    assign ovalid    = (state_q == S_STREAM);
    assign busy      = (state_q == S_STREAM);
    assign ostart    = spend_q;
    assign obyte     = sreg_q[DW-1 -: 8];
    assign last_ip   = last_ip_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_png_feed_ctrl.sv
// tb_png_feed_ctrl: directed and randomized packets against a byte-queue reference model.
// Build with PORT_FILTER_EN defined to exercise the port filter path.
module tb_png_feed_ctrl;

    localparam int unsigned NB = 69;
    localparam int unsigned DW = 8 * NB;

    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   ip;
        logic [15:0]   port;
        logic          first;
        logic [6:0]    nb;
    } pkt_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pkt_valid;
    logic          pkt_ready;
    logic [DW-1:0] pkt_data;
    logic [31:0]   pkt_ip;
    logic [15:0]   pkt_port;
    logic          pkt_first;
    logic [6:0]    pkt_nbytes;
    logic          ostart;
    logic          ovalid;
    logic [7:0]    obyte;
    logic          iready;
    logic          busy;
    logic [31:0]   last_ip;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    png_feed_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_data   (pkt_data),
        .pkt_ip     (pkt_ip),
        .pkt_port   (pkt_port),
        .pkt_first  (pkt_first),
        .pkt_nbytes (pkt_nbytes),
        .ostart     (ostart),
        .ovalid     (ovalid),
        .obyte      (obyte),
        .iready     (iready),
        .busy       (busy),
        .last_ip    (last_ip),
        .pkt_cnt    (pkt_cnt),
        .drop_cnt   (drop_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ip;
    logic [15:0] exp_cnt;
    logic [15:0] exp_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampn(input logic [6:0] nb);
        if (nb == 7'd0 || int'(nb) > NB) return NB;
        return int'(nb);
    endfunction

    function automatic logic [7:0] byte_at(input logic [DW-1:0] d, input int i);
        return d[DW-1-8*i -: 8];
    endfunction

    function automatic logic pick_ready(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic pkt_t rand_pkt();
        pkt_t p;
        logic [575:0] tmp;
        for (int i = 0; i < 18; i++) tmp[i*32 +: 32] = $urandom();
        p.data  = tmp[DW-1:0];
        p.ip    = $urandom();
        p.port  = 16'd8080;
        p.first = 1'($urandom_range(0, 1));
        p.nb    = 7'($urandom_range(0, 127));
        return p;
    endfunction

    task automatic offer(input pkt_t p);
        pkt_valid  = 1'b1;
        pkt_data   = p.data;
        pkt_ip     = p.ip;
        pkt_port   = p.port;
        pkt_first  = p.first;
        pkt_nbytes = p.nb;
    endtask

    // Entered at a negedge with p on the bus; returns at the negedge after the last byte.
    task automatic stream(input pkt_t p, input int mode, input bit load_next, input pkt_t nxt);
        int n;
        int idx;
        int k;
        int budget;
        check("accept_ready", 64'(pkt_ready), 64'd1);
        check("idle_ovalid", 64'(ovalid), 64'd0);
        @(posedge clk);
        if (exp_cnt != 16'hFFFF) exp_cnt++;
        exp_ip = p.ip;
        @(negedge clk);
        if (load_next) offer(nxt);
        else pkt_valid = 1'b0;
        n = clampn(p.nb);
        idx = 0;
        k = 0;
        budget = 2000;
        while (idx < n && budget > 0) begin
            check("ovalid", 64'(ovalid), 64'd1);
            check("obyte", 64'(obyte), 64'(byte_at(p.data, idx)));
            check("ostart", 64'(ostart), 64'(p.first && idx == 0));
            check("busy_ready", 64'({busy, pkt_ready}), 64'b10);
            iready = pick_ready(mode, k);
            @(posedge clk);
            if (iready) idx++;
            k++;
            budget--;
            @(negedge clk);
        end
        if (budget == 0) check("stream_timeout", 64'(idx), 64'(n));
        check("end_ovalid", 64'(ovalid), 64'd0);
        check("end_ready", 64'(pkt_ready), 64'd1);
        check("end_ostart", 64'(ostart), 64'd0);
        check("pkt_cnt", 64'(pkt_cnt), 64'(exp_cnt));
        check("last_ip", 64'(last_ip), 64'(exp_ip));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(pkt_ready), 64'd1);
        check({tag, "_ovalid"}, 64'(ovalid), 64'd0);
        check({tag, "_ostart"}, 64'(ostart), 64'd0);
        check({tag, "_obyte"}, 64'(obyte), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_last_ip"}, 64'(last_ip), 64'd0);
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'd0);
        check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        pkt_t p, a, b;
        pkt_t pk[8];
        rst        = 1'b1;
        pkt_valid  = 1'b0;
        pkt_data   = '0;
        pkt_ip     = 32'd0;
        pkt_port   = 16'd0;
        pkt_first  = 1'b0;
        pkt_nbytes = 7'd0;
        iready     = 1'b0;
        exp_ip     = 32'd0;
        exp_cnt    = 16'd0;
        exp_drop   = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full packet carrying byte values 0x00..0x44, decoder always ready.
        p = rand_pkt();
        for (int i = 0; i < NB; i++) p.data[DW-1-8*i -: 8] = 8'(i);
        p.first = 1'b1;
        p.nb    = 7'd69;
        offer(p);
        stream(p, 0, 1'b0, p);
        check("pkt_cnt_first", 64'(pkt_cnt), 64'd1);

        // Same packet under a 1,0,0,1 back-pressure pattern.
        offer(p);
        stream(p, 1, 1'b0, p);

        // Short packet: only AA..EE may appear.
        p = rand_pkt();
        p.data[DW-1 -: 40] = 40'hAABBCCDDEE;
        p.nb = 7'd5;
        offer(p);
        stream(p, 2, 1'b0, p);

        // Zero byte count means a full packet.
        p = rand_pkt();
        p.nb = 7'd0;
        offer(p);
        stream(p, 0, 1'b0, p);

        // Back-to-back packets with pkt_valid held high.
        a = rand_pkt();
        a.first = 1'b1;
        a.nb    = 7'd12;
        b = rand_pkt();
        b.first = 1'b0;
        b.nb    = 7'd9;
        iready  = 1'b1;
        offer(a);
        stream(a, 0, 1'b1, b);
        stream(b, 0, 1'b0, b);

        // Reset while byte 10 of a full packet is on the bus.
        p = rand_pkt();
        p.nb = 7'd69;
        offer(p);
        @(posedge clk);
        @(negedge clk);
        pkt_valid = 1'b0;
        iready    = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_obyte10", 64'(obyte), 64'(byte_at(p.data, 10)));
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst      = 1'b0;
        exp_cnt  = 16'd0;
        exp_ip   = 32'd0;
        exp_drop = 16'd0;
        @(negedge clk);

        // Port 80 then port 8080.
        a = rand_pkt();
        a.port = 16'd80;
        a.nb   = 7'd4;
        b = rand_pkt();
        b.first = 1'b1;
        b.nb    = 7'd69;
`ifdef PORT_FILTER_EN
        offer(a);
        check("drop_accept_ready", 64'(pkt_ready), 64'd1);
        @(posedge clk);
        exp_drop = 16'd1;
        @(negedge clk);
        check("drop_ovalid", 64'(ovalid), 64'd0);
        check("drop_cnt_one", 64'(drop_cnt), 64'd1);
        check("drop_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("drop_last_ip", 64'(last_ip), 64'd0);
        offer(b);
        stream(b, 2, 1'b0, b);
        check("filter_pkt_cnt", 64'(pkt_cnt), 64'd1);
`else
        offer(a);
        stream(a, 0, 1'b0, a);
        offer(b);
        stream(b, 2, 1'b0, b);
        check("nofilter_pkt_cnt", 64'(pkt_cnt), 64'd2);
`endif

        // Randomized packets, ready patterns and inter-packet gaps.
        for (int i = 0; i < 8; i++) pk[i] = rand_pkt();
        offer(pk[0]);
        for (int i = 0; i < 8; i++) begin
            bit last;
            bit b2b;
            last = (i == 7);
            b2b  = !last && 1'($urandom_range(0, 1));
            stream(pk[i], int'($urandom_range(0, 2)), b2b, pk[last ? i : i + 1]);
            if (!last && !b2b) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    check("gap_ovalid", 64'(ovalid), 64'd0);
                end
                offer(pk[i + 1]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
